// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - func codes, FSM states and op decode for the mult/div unit
package muldiv_unit_pkg;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic is_valid_op(input logic [1:0] aluop, input logic [5:0] fn);
    return (aluop == ALUOP_RTYPE) &&
           (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                       FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between pipeline and mult/div unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic [1:0]       ALUop;
  logic [5:0]       func;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output ALUop, func, start, a, b,
    input  busy, stall, done, div_by_zero, hi, lo, rd_data
  );

  modport slave (
    input  ALUop, func, start, a, b,
    output busy, stall, done, div_by_zero, hi, lo, rd_data
  );
endinterface

// File: rtl/muldiv_unit_twos_negate.sv
// rtl/muldiv_unit_twos_negate.sv - combinational two's-complement negate
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] out_val
);
  assign out_val = ~in_val + WIDTH'(1);
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - radix-2 iterative mult/div with HI/LO and mf/mt access
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, shf_q, shf_d, opb_q, opb_d, araw_q, araw_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic             busy_q, busy_d, done_q, done_d, dzo_q, dzo_d;

  logic             valid, req, is_md, signed_op, div_op, sa, sb;
  logic [WIDTH-1:0] neg_a, neg_b, mag_a, mag_b, neg_quot, neg_rem;
  logic [2*WIDTH-1:0] neg_p;
  logic [WIDTH:0]   mul_sum, div_shifted;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign valid     = is_valid_op(bus.ALUop, bus.func);
  assign req       = bus.start & valid;
  assign is_md     = bus.func[3];
  assign div_op    = bus.func[1];
  assign signed_op = ~bus.func[0];
  assign sa        = signed_op & bus.a[WIDTH-1];
  assign sb        = signed_op & bus.b[WIDTH-1];

  twos_negate #(.WIDTH(WIDTH))   u_neg_a (.in_val(bus.a),          .out_val(neg_a));
  twos_negate #(.WIDTH(WIDTH))   u_neg_b (.in_val(bus.b),          .out_val(neg_b));
  twos_negate #(.WIDTH(2*WIDTH)) u_neg_p (.in_val({acc_q, shf_q}), .out_val(neg_p));
  twos_negate #(.WIDTH(WIDTH))   u_neg_q (.in_val(shf_q),          .out_val(neg_quot));
  twos_negate #(.WIDTH(WIDTH))   u_neg_r (.in_val(acc_q),          .out_val(neg_rem));

  assign mag_a = sa ? neg_a : bus.a;
  assign mag_b = sb ? neg_b : bus.b;

  // Multiply: acc:shf is the running product, multiplier bits retire from shf[0].
  assign mul_sum = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opb_q} : '0);
  // Divide: acc is the partial remainder, shf shifts dividend out and quotient in.
  assign div_shifted = {acc_q, shf_q[WIDTH-1]};
  assign div_ge      = div_shifted >= {1'b0, opb_q};
  assign div_diff    = div_shifted[WIDTH-1:0] - opb_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shf_d    = shf_q;
    opb_d    = opb_q;
    araw_d   = araw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dzo_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (is_md) begin
            state_d  = S_RUN;
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            shf_d    = div_op ? mag_a : mag_b;
            opb_d    = div_op ? mag_b : mag_a;
            araw_d   = bus.a;
            is_div_d = div_op;
            neg_d    = sa ^ sb;
            rneg_d   = sa;
            dz_d     = div_op & (bus.b == '0);
          end else if (bus.func == FN_MTHI) begin
            hi_d = bus.a;
          end else if (bus.func == FN_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          acc_d = div_ge ? div_diff : div_shifted[WIDTH-1:0];
          shf_d = {shf_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          shf_d = {mul_sum[0], shf_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dzo_d   = dz_q;
        if (is_div_q) begin
          if (dz_q) begin
            lo_d = '1;
            hi_d = araw_q;
          end else begin
            lo_d = neg_q  ? neg_quot : shf_q;
            hi_d = rneg_q ? neg_rem  : acc_q;
          end
        end else begin
          {hi_d, lo_d} = neg_q ? neg_p : {acc_q, shf_q};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      shf_q    <= '0;
      opb_q    <= '0;
      araw_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dzo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shf_q    <= shf_d;
      opb_q    <= opb_d;
      araw_q   <= araw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dzo_q    <= dzo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.stall       = req & busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dzo_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.rd_data     = (bus.ALUop == ALUOP_RTYPE && bus.func == FN_MFHI) ? hi_q :
                           (bus.ALUop == ALUOP_RTYPE && bus.func == FN_MFLO) ? lo_q : '0;
endmodule
